frog_zone_tracker: RTL
======================

Name: frog_zone_tracker

Overview:
- Consumer of the grass row-range outputs (arrival, middle, spawn zones).
- Classifies the frog's current row into a zone.
- Detects arrival: celebrate, then level up and respawn.
- Detects a collision on a road row: death, then level reset and respawn.
- Sits between the frog movement logic and the score/VGA overlay logic.

Parameters:
- ROW_W, 4: width of frog row index (16 rows).
- CELEBRATE_CYCLES, 25000000: cycles held in CELEBRATE before respawn (1 s at 25 MHz).
- DEATH_CYCLES, 12500000: cycles held in DEAD before respawn.
- MAX_LEVEL, 9: level at which WIN is entered.
- LEVEL_W, 4: width of level counter.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_frog_row  in  ROW_W  current frog row, 0 = top.
- i_move_valid  in  1  one-cycle pulse: frog just moved, i_frog_row is the new row.
- i_collision  in  1  one-cycle pulse: frog overlaps a vehicle.
- i_arrival_start, i_arrival_end  in  10  arrival zone rows, inclusive.
- i_middle_start, i_middle_end  in  10  middle safe zone rows, inclusive.
- i_spawn_start, i_spawn_end  in  10  spawn zone rows, inclusive.
- o_zone  out  2  registered zone of i_frog_row: 0 road, 1 arrival, 2 middle, 3 spawn.
- o_on_grass  out  1  registered, equals (o_zone != 0).
- o_respawn  out  1  one-cycle pulse: frog movement logic reloads the frog at o_spawn_row.
- o_spawn_row  out  ROW_W  i_spawn_start[ROW_W-1:0], registered.
- o_level  out  LEVEL_W  current level.
- o_win  out  1  sticky win flag.
- o_state  out  2  0 PLAY, 1 CELEBRATE, 2 DEAD, 3 WIN.

Behaviour:
- Reset is asynchronous on the falling edge of i_Rst_n. Reset values:
  - state = PLAY, o_zone = 0, o_on_grass = 0, o_respawn = 0
  - o_spawn_row = 0, o_level = 0, o_win = 0, counter = 0
- Zone compare:
  - i_frog_row is zero-extended to 10 bits; range checks are start <= row <= end.
  - Priority on overlap: arrival > middle > spawn > road.
  - Start > end means the range is empty.
  - The combinational zone (zone_c) is registered into o_zone, giving 1-cycle latency.
- PLAY:
  - i_move_valid with zone_c == arrival:
    - Go to CELEBRATE.
    - o_level increments, saturating at 2^LEVEL_W-1.
    - Clear counter.
  - Else, i_collision with zone_c == road: go to DEAD and clear counter.
  - i_collision while zone_c != road is ignored (frog is safe on grass).
  - Arrival and collision in the same cycle: the arrival path is taken.
- CELEBRATE:
  - Counter increments each cycle.
  - When counter == CELEBRATE_CYCLES-1:
    - If o_level >= MAX_LEVEL: go to WIN, set o_win = 1, no respawn pulse.
    - Otherwise: pulse o_respawn for one cycle, return to PLAY.
  - Inputs are ignored in this state.
- DEAD:
  - Counter increments each cycle.
  - When counter == DEATH_CYCLES-1: o_level := 0, pulse o_respawn, return to PLAY.
  - Inputs are ignored in this state.
- WIN:
  - Absorbing until reset.
  - o_respawn stays 0; o_zone continues to track i_frog_row.
- Counter width is clog2(max(CELEBRATE_CYCLES, DEATH_CYCLES)); it never wraps, because it is cleared on state entry.
- o_respawn is high for exactly one cycle, on the cycle the state returns to PLAY.
- Reset asserted mid-CELEBRATE or mid-DEAD: immediate return to reset values, no respawn pulse.

Decomposition:
- Shared package/header:
  - zone encodings (ZONE_ROAD, ZONE_ARRIVAL, ZONE_MIDDLE, ZONE_SPAWN)
  - state encodings
  - ROW_W
- Sub-module zone_classifier (purely combinational): row plus six range bounds in, 2-bit zone out, priority encoded. It is reused by the VGA lane colouring.
- The FSM and counter stay in frog_zone_tracker.

Test Plan:
- Bounds arrival 0-2, middle 8-9, spawn 15-15; CELEBRATE_CYCLES=4, DEATH_CYCLES=3.
- Zone sweep: step i_frog_row 0..15 with no move pulses -> o_zone one cycle later is 1,1,1,0,0,0,0,0,2,2,0,0,0,0,0,3 and o_on_grass matches.
- Arrival: row 3 -> row 2 with i_move_valid -> o_state=1 next cycle, o_level 0->1; o_respawn pulses exactly 4 cycles after entry; o_state=0.
- Death: row 5, i_collision -> o_state=2; after 3 cycles o_level=0 and o_respawn pulses once; o_spawn_row=15.
- Safe collision: row 8 (middle) with i_collision -> state stays PLAY, no respawn. Row 2 with i_move_valid and i_collision in the same cycle -> CELEBRATE.
- Win: nine arrivals -> after the ninth celebration o_win=1, o_state=3, no respawn pulse; further moves and collisions have no effect.
- Reset mid-operation: assert i_Rst_n=0 two cycles into CELEBRATE -> all outputs return to reset values immediately with no clock edge; after release, state=PLAY and o_level=0.

Source files
------------

// File: rtl/frog_zone_tracker_pkg.sv
// Shared definitions for the frog zone tracker and its zone classifier.
//   - ROW_W       : default frog row index width
//   - BOUND_W     : width of the grass row-range bounds
//   - ZONE_*      : 2-bit zone encodings
//   - state_e     : tracker FSM state encoding
//   - row_in_range: inclusive range test, empty when start > end
package frog_zone_tracker_pkg;

    localparam int unsigned ROW_W   = 4;
    localparam int unsigned BOUND_W = 10;

    localparam logic [1:0] ZONE_ROAD    = 2'd0;
    localparam logic [1:0] ZONE_ARRIVAL = 2'd1;
    localparam logic [1:0] ZONE_MIDDLE  = 2'd2;
    localparam logic [1:0] ZONE_SPAWN   = 2'd3;

    typedef enum logic [1:0] {
        StPlay      = 2'd0,
        StCelebrate = 2'd1,
        StDead      = 2'd2,
        StWin       = 2'd3
    } state_e;

    function automatic logic row_in_range(input logic [BOUND_W-1:0] row,
                                          input logic [BOUND_W-1:0] lo,
                                          input logic [BOUND_W-1:0] hi);
        return (lo <= hi) && (row >= lo) && (row <= hi);
    endfunction

endpackage

// File: rtl/frog_zone_tracker_zone_classifier.sv
// Zone classifier: purely combinational priority encoder mapping a row index onto the
// arrival / middle / spawn grass ranges. Also reused by the VGA lane colouring.
// Ports:
//   i_row                            row index, already zero-extended to BOUND_W
//   i_arrival_start/i_arrival_end    arrival zone rows, inclusive
//   i_middle_start/i_middle_end      middle safe zone rows, inclusive
//   i_spawn_start/i_spawn_end        spawn zone rows, inclusive
//   o_zone                           0 road, 1 arrival, 2 middle, 3 spawn
module frog_zone_tracker_zone_classifier
    import frog_zone_tracker_pkg::*;
(
    input  logic [BOUND_W-1:0] i_row,
    input  logic [BOUND_W-1:0] i_arrival_start,
    input  logic [BOUND_W-1:0] i_arrival_end,
    input  logic [BOUND_W-1:0] i_middle_start,
    input  logic [BOUND_W-1:0] i_middle_end,
    input  logic [BOUND_W-1:0] i_spawn_start,
    input  logic [BOUND_W-1:0] i_spawn_end,
    output logic [1:0]         o_zone
);

    // Overlapping ranges resolve arrival > middle > spawn > road.
    always_comb begin
        o_zone = ZONE_ROAD;
        if (row_in_range(i_row, i_arrival_start, i_arrival_end)) begin
            o_zone = ZONE_ARRIVAL;
        end else if (row_in_range(i_row, i_middle_start, i_middle_end)) begin
            o_zone = ZONE_MIDDLE;
        end else if (row_in_range(i_row, i_spawn_start, i_spawn_end)) begin
            o_zone = ZONE_SPAWN;
        end
    end

endmodule

// File: rtl/frog_zone_tracker.sv
// Frog zone tracker: classifies the frog's row into a zone, runs the play /
// celebrate / dead / win game flow, tracks the level and requests respawns.
// Ports:
//   i_Clk, i_Rst_n                 clock, asynchronous active-low reset
//   i_frog_row                     current frog row, 0 = top
//   i_move_valid                   pulse: frog just moved to i_frog_row
//   i_collision                    pulse: frog overlaps a vehicle
//   i_{arrival,middle,spawn}_*     grass zone row ranges, inclusive
//   o_zone, o_on_grass             registered zone of i_frog_row
//   o_respawn, o_spawn_row         respawn pulse and reload row
//   o_level, o_win, o_state        level, sticky win flag, FSM state
module frog_zone_tracker #(
    parameter int unsigned ROW_W            = frog_zone_tracker_pkg::ROW_W,
    parameter int unsigned CELEBRATE_CYCLES = 25000000,
    parameter int unsigned DEATH_CYCLES     = 12500000,
    parameter int unsigned MAX_LEVEL        = 9,
    parameter int unsigned LEVEL_W          = 4
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [ROW_W-1:0]   i_frog_row,
    input  logic               i_move_valid,
    input  logic               i_collision,
    input  logic [9:0]         i_arrival_start,
    input  logic [9:0]         i_arrival_end,
    input  logic [9:0]         i_middle_start,
    input  logic [9:0]         i_middle_end,
    input  logic [9:0]         i_spawn_start,
    input  logic [9:0]         i_spawn_end,
    output logic [1:0]         o_zone,
    output logic               o_on_grass,
    output logic               o_respawn,
    output logic [ROW_W-1:0]   o_spawn_row,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_win,
    output logic [1:0]         o_state
);

    import frog_zone_tracker_pkg::*;

    localparam int unsigned CntMax = (CELEBRATE_CYCLES > DEATH_CYCLES) ?
                                     CELEBRATE_CYCLES : DEATH_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0]    CelebLast = CntW'(CELEBRATE_CYCLES - 1);
    localparam logic [CntW-1:0]    DeadLast  = CntW'(DEATH_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] MaxLevel  = LEVEL_W'(MAX_LEVEL);

    logic [BOUND_W-1:0] row_ext;
    logic [1:0]         zone_c;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         zone_q, zone_d;
    logic               on_grass_q, on_grass_d;
    logic               respawn_q, respawn_d;
    logic [ROW_W-1:0]   spawn_row_q, spawn_row_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               win_q, win_d;

    assign row_ext = BOUND_W'(i_frog_row);

    frog_zone_tracker_zone_classifier u_zone_classifier (
        .i_row           (row_ext),
        .i_arrival_start (i_arrival_start),
        .i_arrival_end   (i_arrival_end),
        .i_middle_start  (i_middle_start),
        .i_middle_end    (i_middle_end),
        .i_spawn_start   (i_spawn_start),
        .i_spawn_end     (i_spawn_end),
        .o_zone          (zone_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        win_d       = win_q;
        respawn_d   = 1'b0;
        zone_d      = zone_c;
        on_grass_d  = (zone_c != ZONE_ROAD);
        spawn_row_d = i_spawn_start[ROW_W-1:0];

        unique case (state_q)
            StPlay: begin
                // Arrival wins over a simultaneous collision.
                if (i_move_valid && (zone_c == ZONE_ARRIVAL)) begin
                    state_d = StCelebrate;
                    cnt_d   = '0;
                    if (level_q != '1) begin
                        level_d = level_q + 1'b1;
                    end
                end else if (i_collision && (zone_c == ZONE_ROAD)) begin
                    state_d = StDead;
                    cnt_d   = '0;
                end
            end
            StCelebrate: begin
                if (cnt_q == CelebLast) begin
                    if (level_q >= MaxLevel) begin
                        state_d = StWin;
                        win_d   = 1'b1;
                    end else begin
                        state_d   = StPlay;
                        respawn_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDead: begin
                if (cnt_q == DeadLast) begin
                    state_d   = StPlay;
                    level_d   = '0;
                    respawn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWin: begin
                state_d = StWin;
            end
            default: begin
                state_d = StPlay;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= StPlay;
            cnt_q       <= '0;
            zone_q      <= ZONE_ROAD;
            on_grass_q  <= 1'b0;
            respawn_q   <= 1'b0;
            spawn_row_q <= '0;
            level_q     <= '0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            zone_q      <= zone_d;
            on_grass_q  <= on_grass_d;
            respawn_q   <= respawn_d;
            spawn_row_q <= spawn_row_d;
            level_q     <= level_d;
            win_q       <= win_d;
        end
    end

    assign o_zone      = zone_q;
    assign o_on_grass  = on_grass_q;
    assign o_respawn   = respawn_q;
    assign o_spawn_row = spawn_row_q;
    assign o_level     = level_q;
    assign o_win       = win_q;
    assign o_state     = state_q;

endmodule
